step_clock_gen: RTL

- Input-side companion to the board top level: converts a raw, bouncing push-button into a clean single-step clock for the pipelined CPU. The seven-segment path is the output direction; this block is the input direction.
- Runs on the 50 MHz board clock.
- Output stages:
  - 2-FF synchronizer
  - debounce counter
  - rising-edge detector
  - pulse-stretch FSM that emits one fixed-width `cpu_clk` high phase per press
- Also provides a 16-bit step counter for display or debug.

---
 rtl/step_clock_gen.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/step_clock_gen.sv
// Single-step clock generator: synchronize, debounce, and edge-detect a push-button,
// then stretch each press into one fixed-width cpu_clk high phase.
// Optional auto-run trigger: define STEP_CLOCK_AUTO_RUN_EN (adds run_en, RUN_PERIOD).
module step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CLK_HIGH_CYCLES = 4,
  parameter int unsigned CNT_W           = 20
`ifdef STEP_CLOCK_AUTO_RUN_EN
  ,
  parameter int unsigned RUN_PERIOD      = 25000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_raw,
`ifdef STEP_CLOCK_AUTO_RUN_EN
  input  logic        run_en,
`endif
  output logic        btn_level,
  output logic        cpu_clk,
  output logic        step_pulse,
  output logic [15:0] step_count
);

  localparam int unsigned HCNT_W = (CLK_HIGH_CYCLES > 1) ? $clog2(CLK_HIGH_CYCLES) : 1;

  typedef enum logic [0:0] {StIdle, StHigh} state_e;

  logic              s1_q, s2_q;
  logic [CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic              btn_level_q, btn_level_d;
  logic              level_dly_q;
  logic              rise;
  logic              step_trig;
  state_e            state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              cpu_clk_q, cpu_clk_d;
  logic              step_pulse_q, step_pulse_d;
  logic [15:0]       step_count_q, step_count_d;

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive disagreements.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    if (s2_q == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_level_d = s2_q;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise = btn_level_q & ~level_dly_q;

`ifdef STEP_CLOCK_AUTO_RUN_EN
  localparam int unsigned RUN_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_trig;

  always_comb begin
    run_cnt_d = run_cnt_q;
    run_trig  = 1'b0;
    if (!run_en) begin
      run_cnt_d = '0;
    end else if (run_cnt_q == RUN_W'(RUN_PERIOD - 1)) begin
      run_cnt_d = '0;
      run_trig  = 1'b1;
    end else begin
      run_cnt_d = run_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  // Coincident button rise and timer trigger collapse into a single step.
  assign step_trig = rise | run_trig;
`else
  assign step_trig = rise;
`endif

  // Triggers arriving while already in StHigh are dropped, not queued.
  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    cpu_clk_d    = cpu_clk_q;
    step_pulse_d = 1'b0;
    step_count_d = step_count_q;
    unique case (state_q)
      StIdle: begin
        cpu_clk_d = 1'b0;
        if (step_trig) begin
          state_d      = StHigh;
          cpu_clk_d    = 1'b1;
          step_pulse_d = 1'b1;
          step_count_d = step_count_q + 16'd1;
          hcnt_d       = '0;
        end
      end
      StHigh: begin
        if (hcnt_q == HCNT_W'(CLK_HIGH_CYCLES - 1)) begin
          cpu_clk_d = 1'b0;
          state_d   = StIdle;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        cpu_clk_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      level_dly_q  <= 1'b0;
      state_q      <= StIdle;
      hcnt_q       <= '0;
      cpu_clk_q    <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= 16'd0;
    end else begin
      s1_q         <= btn_raw;
      s2_q         <= s1_q;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      level_dly_q  <= btn_level_q;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      cpu_clk_q    <= cpu_clk_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign btn_level  = btn_level_q;
  assign cpu_clk    = cpu_clk_q;
  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;

endmodule
